sle_pipe: RTL and testbench

- Parametrised successor to the single-bit storage element: a DEPTH-stage, WIDTH-bit elastic register pipeline.
- Each stage keeps the element's enable and active-low synchronous-load semantics, and adds per-stage valid tracking with bubble collapsing.
- Sits between a producer and a consumer as a retiming and buffering stage, using a valid/ready handshake on both sides.

---
 rtl/sle_pipe.sv | 81 ++++++++
 tb/tb_sle_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sle_pipe.sv
// Elastic DEPTH-stage, WIDTH-bit register pipeline with valid/ready handshakes on both sides.
// Each stage keeps enable and active-low synchronous-load behaviour; empty stages collapse bubbles.
module sle_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         sln,
    input  logic [WIDTH-1:0]             sd,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             d,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] v_r;
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    cnt_r;
    logic             run;
    logic             push;
    logic             pop;

    // A stage may load when it is empty or anything downstream of it can move.
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            acc    = acc | ~v_r[i];
            rdy[i] = acc;
        end
    end

    assign run       = en & sln;
    assign in_ready  = ~rst & run & rdy[0];
    assign push      = in_valid & in_ready;
    assign pop       = v_r[DEPTH-1] & out_ready & run;
    assign out_valid = v_r[DEPTH-1] & en;
    assign q         = data_r[DEPTH-1];
    assign count     = cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) data_r[i] <= RESET_VAL;
            v_r   <= '0;
            cnt_r <= '0;
        end else if (en) begin
            if (!sln) begin
                for (int i = 0; i < DEPTH; i++) data_r[i] <= sd;
                v_r   <= '0;
                cnt_r <= '0;
            end else begin
                // Data moves with its valid bit, so bubble data also shifts forward.
                if (rdy[0]) begin
                    data_r[0] <= d;
                    v_r[0]    <= in_valid;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (rdy[i]) begin
                        data_r[i] <= data_r[i-1];
                        v_r[i]    <= v_r[i-1];
                    end
                end
                if (push && !pop)
                    cnt_r <= cnt_r + CW'(1);
                else if (pop && !push)
                    cnt_r <= cnt_r - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sle_pipe.sv
// Scoreboard bench for sle_pipe: stimulus pushes accepted words into a queue, a negedge monitor
// pops and compares on every downstream transfer, alongside directed latency/flush/freeze scenarios.
module tb_sle_pipe;

    localparam int             WIDTH = 8;
    localparam int             DEPTH = 4;
    localparam logic [7:0]     RV    = 8'h5A;
    localparam int             CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst, en, sln, in_valid, out_ready;
    logic [WIDTH-1:0] sd, d, q;
    logic             in_ready, out_valid;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;
    int npops  = 0;
    int mcnt   = 0;
    logic [WIDTH-1:0] sb [$];

    sle_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .sln(sln), .sd(sd),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (count == 0 && sb.size() == 0) done = 1;
            else tick();
        end
        check("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    // Monitor: the pipe behaves as a FIFO of capacity DEPTH; in_ready is high whenever
    // it is not full or the consumer is taking a word this cycle.
    always @(negedge clk) begin
        logic exp_ir;
        if (rst) begin
            sb.delete();
            mcnt = 0;
            check("rst_count", {29'd0, count}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            exp_ir = en && sln && (mcnt < DEPTH || out_ready);
            check("count", {29'd0, count}, mcnt);
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            if (!en || mcnt == 0)
                check("out_valid_low", {31'd0, out_valid}, 32'd0);
            if (en && !sln) begin
                sb.delete();
                mcnt = 0;
            end else begin
                if (out_valid && out_ready && en && sln) begin
                    npops++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got %0h expected no word", q);
                    end else begin
                        check("pop_data", {24'd0, q}, {24'd0, sb.pop_front()});
                    end
                    mcnt--;
                end
                if (in_valid && in_ready) begin
                    sb.push_back(d);
                    mcnt++;
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] qsave;
        int p0;
        rst = 1; en = 1; sln = 1; in_valid = 0; out_ready = 0; d = '0; sd = '0;

        // Reset values, then asynchronous reset mid-cycle with words in flight
        tick(); tick();
        check("reset_q", {24'd0, q}, {24'd0, RV});
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 0;
        in_valid = 1; d = 8'hE1; tick();
        d = 8'hE2; tick();
        in_valid = 0;
        @(posedge clk); #3;
        rst = 1; #1;
        check("async_rst_q", {24'd0, q}, {24'd0, RV});
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_count", {29'd0, count}, 32'd0);
        tick();
        rst = 0;

        // Latency: DEPTH edges from acceptance to q
        out_ready = 1; in_valid = 1; d = 8'h11;
        tick();
        in_valid = 0;
        tick(); tick();
        check("latency_early", {31'd0, out_valid}, 32'd0);
        tick();
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_q", {24'd0, q}, 32'h11);
        wait_drain();

        // Streaming 01..10 back-to-back
        p0 = npops;
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1; d = 8'(i + 1);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i >= DEPTH) check("stream_count", {29'd0, count}, DEPTH);
            tick();
        end
        in_valid = 0;
        wait_drain();
        check("stream_pops", npops - p0, 32'd16);

        // Backpressure: only DEPTH of 6 accepted
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; d = 8'(8'hA0 + i);
            #1;
            check("bp_in_ready", {31'd0, in_ready}, {31'd0, i < DEPTH});
            tick();
        end
        in_valid = 0;
        check("bp_count", {29'd0, count}, DEPTH);
        out_ready = 1; #1;
        check("bp_ready_return", {31'd0, in_ready}, 32'd1);
        wait_drain();

        // Bubble collapse
        out_ready = 0;
        in_valid = 1; d = 8'hA5; tick();
        in_valid = 0; tick(); tick();
        in_valid = 1; d = 8'h3C; tick();
        in_valid = 0;
        repeat (4) tick();
        check("bubble_count", {29'd0, count}, 32'd2);
        check("bubble_out_valid", {31'd0, out_valid}, 32'd1);
        check("bubble_q_a", {24'd0, q}, 32'hA5);
        out_ready = 1; tick();
        check("bubble_q_b", {24'd0, q}, 32'h3C);
        check("bubble_b_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bubble_empty", {29'd0, count}, 32'd0);
        out_ready = 0;

        // Flush with 3 words held
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; d = 8'(8'h61 + i); tick();
        end
        in_valid = 1; d = 8'h99; sln = 0; sd = 8'hC3;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        sln = 1; in_valid = 0;
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_q", {24'd0, q}, 32'hC3);
        p0 = npops;
        out_ready = 1;
        repeat (8) tick();
        check("flush_no_pops", npops - p0, 32'd0);

        // Enable freeze with 2 words in flight
        in_valid = 1; d = 8'h77; tick();
        d = 8'h88; tick();
        en = 0; d = 8'hFF;
        qsave = q;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("freeze_in_ready", {31'd0, in_ready}, 32'd0);
            check("freeze_out_valid", {31'd0, out_valid}, 32'd0);
            check("freeze_count", {29'd0, count}, 32'd2);
            check("freeze_q", {24'd0, q}, {24'd0, qsave});
        end
        p0 = npops;
        en = 1; in_valid = 0;
        wait_drain();
        check("freeze_resume_pops", npops - p0, 32'd2);

        // Randomized traffic with occasional freeze and flush
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            d         = 8'($urandom);
            sd        = 8'($urandom);
            en        = ($urandom_range(0, 15) != 0);
            sln       = ($urandom_range(0, 39) != 0);
            tick();
        end
        en = 1; sln = 1; in_valid = 0; out_ready = 1;
        wait_drain();
        check("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
